fft_peak_reader: RTL and testbench
==================================

Name: fft_peak_reader

Overview:
- Read-side consumer of the FFT processor's result memory.
- When the FFT control unit pulses done, the block takes the memory read port by asserting rd_sel, then sweeps rd_adr over the positive-frequency bins.
- For each bin it computes a magnitude metric from the returned complex word and tracks the largest one.
- It then reports peak bin index and magnitude to the tuner's pitch logic.

Parameters:
- bit_width, 16, width of each signed real/imag result component
- N, 512, FFT length (power of two)
- M, $clog2(N), address width of result memory
- MIN_BIN, 1, first bin swept (bins below, incl. DC, never considered); legal 0..N/2-1

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- done  input  1  one-cycle pulse from fft_control_unit: results valid in memory
- rd_data_re  input  bit_width  signed real part of word addressed by previous cycle's rd_adr
- rd_data_im  input  bit_width  signed imag part, same timing
- rd_adr  output  M  result memory read address
- rd_sel  output  1  1 = reader owns memory read port
- busy  output  1  1 while sweep in progress (SWEEP or DRAIN)
- peak_valid  output  1  one-cycle pulse: peak_bin/peak_mag updated
- peak_bin  output  M  index of largest-magnitude bin of last completed sweep
- peak_mag  output  2*bit_width  unsigned magnitude metric of peak_bin, zero-extended

Behaviour:
- Clock and reset:
  - One clock; reset sampled on rising clk, active-low, synchronous.
  - Reset in any state: state=IDLE; rd_adr=0, rd_sel=0, busy=0, peak_valid=0, peak_bin=0, peak_mag=0; internal best/counters cleared.
  - A sweep aborted by reset never produces peak_valid.
- Memory read timing: synchronous read, 1-cycle latency; address presented in cycle t returns data in cycle t+1.
- FSM states IDLE, SWEEP, DRAIN, REPORT:
  - IDLE: rd_sel=0, busy=0. done=1 -> SWEEP; rd_adr=MIN_BIN and rd_sel=1 from the next cycle. Best metric cleared to 0, best bin to MIN_BIN.
  - SWEEP: rd_sel=1, busy=1; rd_adr increments by 1 per cycle. Cycle with rd_adr=N/2-1 -> DRAIN.
  - DRAIN: one cycle. rd_sel=1, busy=1, rd_adr held at N/2-1. Last data word is compared. -> REPORT.
  - REPORT: rd_sel=0, busy=0. peak_valid=1 for exactly this cycle, and peak_bin/peak_mag already show the new result in this cycle. -> IDLE.
- Outputs hold: peak_bin/peak_mag keep their values until the next REPORT.
- Compare stage: on every cycle whose previous cycle issued an address in SWEEP (and on the DRAIN cycle), metric of the returned data is compared with the best value. Strictly greater replaces the best and records that address, delayed 1 cycle. Ties keep the lower bin.
- Latency: done in cycle 0 -> SWEEP cycles 1..(N/2-MIN_BIN) -> DRAIN at N/2-MIN_BIN+1 -> peak_valid at N/2-MIN_BIN+2. For N=512, MIN_BIN=1: 255 reads, peak_valid at cycle 257.
- done while busy or in REPORT: ignored, no restart, no queuing.
- Default metric: |re|+|im|.
  - abs computed in bit_width+1 bits, so -2^(bit_width-1) maps to +2^(bit_width-1) with no overflow.
  - Sum is bit_width+2 bits unsigned, zero-extended to 2*bit_width.
- All-zero data: peak_bin=MIN_BIN, peak_mag=0.

Optional Feature:
- Macro FFT_PEAK_SQMAG_EN.
- Defined: metric = re*re + im*im; signed products, unsigned sum, full 2*bit_width width (max 2^(2*bit_width-1), fits). Multiply is registered as an extra pipeline stage, so DRAIN lasts 2 cycles and peak_valid moves one cycle later (cycle 258 for defaults).
- Undefined: L1 metric, timing as above.

Test Plan:
- Single tone: memory all zero except bin 40 = (re 1000, im -600) -> peak_valid at cycle 257 after done, peak_bin=40, peak_mag=1600 (SQMAG: 1360000 at cycle 258). rd_adr must sweep 1..255 with rd_sel=1 during cycles 1..256.
- Tie and DC skip: bin 0 = (30000,0), bins 10 and 20 = (500,500), rest 0 -> peak_bin=10, peak_mag=1000. Bin 0 is never addressed.
- Extremes: bin 255 = (-32768,-32768) -> peak_bin=255, peak_mag=65536 (SQMAG: 2147483648), confirming last-bin DRAIN compare and no abs overflow.
- All zero -> peak_bin=1, peak_mag=0, exactly one peak_valid pulse.
- done re-pulsed at cycles 50 and 257 after the first done -> ignored, single peak_valid, no address restart. A done pulse at cycle 259 (back in IDLE) starts a new sweep.
- reset low at cycle 100 of a sweep -> next cycle all outputs 0, state IDLE, no peak_valid. A following done produces a correct full sweep.

Source files
------------

// File: rtl/fft_peak_reader.sv
// Sweeps the FFT result memory over bins MIN_BIN..N/2-1 after done and reports the strongest bin.
// Optional macro FFT_PEAK_SQMAG_EN selects the re^2+im^2 metric (one extra pipeline stage).
module fft_peak_reader #(
  parameter int bit_width = 16,
  parameter int N         = 512,
  parameter int M         = $clog2(N),
  parameter int MIN_BIN   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   done,
  input  logic [bit_width-1:0]   rd_data_re,
  input  logic [bit_width-1:0]   rd_data_im,
  output logic [M-1:0]           rd_adr,
  output logic                   rd_sel,
  output logic                   busy,
  output logic                   peak_valid,
  output logic [M-1:0]           peak_bin,
  output logic [2*bit_width-1:0] peak_mag
);

  localparam int MW = 2 * bit_width;
  localparam logic [M-1:0] FIRST_ADR = M'(MIN_BIN);
  localparam logic [M-1:0] LAST_ADR  = M'(N / 2 - 1);
  localparam logic [M-1:0] ONE_ADR   = {{(M-1){1'b0}}, 1'b1};
`ifdef FFT_PEAK_SQMAG_EN
  localparam logic DRAIN_LAST = 1'b1;
`else
  localparam logic DRAIN_LAST = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWEEP  = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } state_t;

`ifdef FFT_PEAK_SQMAG_EN
  function automatic logic [MW-1:0] sq_f(input logic [bit_width-1:0] v);
    logic signed [MW-1:0] ext;
    ext  = {{bit_width{v[bit_width-1]}}, v};
    sq_f = $unsigned(ext * ext);
  endfunction
`else
  // Extra bit keeps the most negative input representable after negation.
  function automatic logic [bit_width:0] abs_f(input logic [bit_width-1:0] v);
    logic [bit_width:0] ext;
    ext = {v[bit_width-1], v};
    if (v[bit_width-1]) begin
      abs_f = (~ext) + {{bit_width{1'b0}}, 1'b1};
    end else begin
      abs_f = ext;
    end
  endfunction
`endif

  state_t             state_r;
  logic               valid_d_r;
  logic [M-1:0]       adr_d_r;
  logic [MW-1:0]      best_mag_r;
  logic [M-1:0]       best_bin_r;
  logic               drain_cnt_r;
  logic [MW-1:0]      metric_s;
  logic               cmp_valid_s;
  logic [MW-1:0]      cmp_metric_s;
  logic [M-1:0]       cmp_adr_s;
  logic [MW-1:0]      nxt_mag_s;
  logic [M-1:0]       nxt_bin_s;
  logic               drain_done_s;
`ifdef FFT_PEAK_SQMAG_EN
  logic               sq_valid_r;
  logic [M-1:0]       sq_adr_r;
  logic [MW-1:0]      sq_mag_r;
`else
  logic [bit_width+1:0] l1_s;
`endif

  // Metric of the returned word and strict-greater update of the running best.
  always_comb begin
`ifdef FFT_PEAK_SQMAG_EN
    metric_s     = sq_f(rd_data_re) + sq_f(rd_data_im);
    cmp_valid_s  = sq_valid_r;
    cmp_metric_s = sq_mag_r;
    cmp_adr_s    = sq_adr_r;
`else
    l1_s         = {1'b0, abs_f(rd_data_re)} + {1'b0, abs_f(rd_data_im)};
    metric_s     = {{(MW-bit_width-2){1'b0}}, l1_s};
    cmp_valid_s  = valid_d_r;
    cmp_metric_s = metric_s;
    cmp_adr_s    = adr_d_r;
`endif
    if (cmp_valid_s && (cmp_metric_s > best_mag_r)) begin
      nxt_mag_s = cmp_metric_s;
      nxt_bin_s = cmp_adr_s;
    end else begin
      nxt_mag_s = best_mag_r;
      nxt_bin_s = best_bin_r;
    end
    drain_done_s = (drain_cnt_r == DRAIN_LAST);
  end

  // Align the issued address with the data returned one cycle later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_d_r  <= 1'b0;
      adr_d_r    <= '0;
`ifdef FFT_PEAK_SQMAG_EN
      sq_valid_r <= 1'b0;
      sq_adr_r   <= '0;
      sq_mag_r   <= '0;
`endif
    end else begin
      valid_d_r  <= (state_r == SWEEP);
      adr_d_r    <= rd_adr;
`ifdef FFT_PEAK_SQMAG_EN
      sq_valid_r <= valid_d_r;
      sq_adr_r   <= adr_d_r;
      sq_mag_r   <= metric_s;
`endif
    end
  end

  // Sweep controller with registered memory-port and result outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      rd_adr      <= '0;
      rd_sel      <= 1'b0;
      busy        <= 1'b0;
      peak_valid  <= 1'b0;
      peak_bin    <= '0;
      peak_mag    <= '0;
      best_mag_r  <= '0;
      best_bin_r  <= '0;
      drain_cnt_r <= 1'b0;
    end else begin
      peak_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (done) begin
            state_r     <= SWEEP;
            rd_adr      <= FIRST_ADR;
            rd_sel      <= 1'b1;
            busy        <= 1'b1;
            best_mag_r  <= '0;
            best_bin_r  <= FIRST_ADR;
            drain_cnt_r <= 1'b0;
          end
        end
        SWEEP: begin
          best_mag_r <= nxt_mag_s;
          best_bin_r <= nxt_bin_s;
          if (rd_adr == LAST_ADR) begin
            state_r     <= DRAIN;
            drain_cnt_r <= 1'b0;
          end else begin
            rd_adr <= rd_adr + ONE_ADR;
          end
        end
        DRAIN: begin
          best_mag_r <= nxt_mag_s;
          best_bin_r <= nxt_bin_s;
          if (drain_done_s) begin
            // The last compare result goes straight to the outputs.
            state_r    <= REPORT;
            rd_sel     <= 1'b0;
            busy       <= 1'b0;
            peak_valid <= 1'b1;
            peak_bin   <= nxt_bin_s;
            peak_mag   <= nxt_mag_s;
          end else begin
            drain_cnt_r <= drain_cnt_r + 1'b1;
          end
        end
        REPORT: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          rd_sel  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_peak_reader.sv
// Self-checking bench for fft_peak_reader: directed table, randomized sweeps against an array-scan model, reset abort.
module tb_fft_peak_reader;

  localparam int BW        = 16;
  localparam int N         = 512;
  localparam int M         = $clog2(N);
  localparam int MIN_BIN   = 1;
  localparam int HALF      = N / 2;
  localparam int SWEEP_LEN = HALF - MIN_BIN;
`ifdef FFT_PEAK_SQMAG_EN
  localparam int DRAIN_CYC = 2;
`else
  localparam int DRAIN_CYC = 1;
`endif
  localparam int LAT = SWEEP_LEN + DRAIN_CYC + 1;

  typedef struct {
    int     b0; int r0; int i0;
    int     b1; int r1; int i1;
    int     b2; int r2; int i2;
    int     eb;
    longint em;
    int     rd1; int rd2;
  } vec_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            done;
  logic [BW-1:0]   rd_data_re;
  logic [BW-1:0]   rd_data_im;
  logic [M-1:0]    rd_adr;
  logic            rd_sel;
  logic            busy;
  logic            peak_valid;
  logic [M-1:0]    peak_bin;
  logic [2*BW-1:0] peak_mag;

  int mem_re[N];
  int mem_im[N];
  int checks = 0;
  int errors = 0;

  fft_peak_reader #(.bit_width(BW), .N(N), .M(M), .MIN_BIN(MIN_BIN)) dut (
    .clk(clk), .reset(reset), .done(done),
    .rd_data_re(rd_data_re), .rd_data_im(rd_data_im),
    .rd_adr(rd_adr), .rd_sel(rd_sel), .busy(busy), .peak_valid(peak_valid),
    .peak_bin(peak_bin), .peak_mag(peak_mag)
  );

  always #5 clk = ~clk;

  // Result memory: synchronous read, one cycle latency.
  always @(posedge clk) begin
    rd_data_re <= BW'(mem_re[rd_adr]);
    rd_data_im <= BW'(mem_im[rd_adr]);
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint metric_f(input int re, input int im);
`ifdef FFT_PEAK_SQMAG_EN
    return longint'(re) * longint'(re) + longint'(im) * longint'(im);
`else
    return longint'(re < 0 ? -re : re) + longint'(im < 0 ? -im : im);
`endif
  endfunction

  task automatic model_peak(output int b, output longint m);
    longint v;
    b = MIN_BIN;
    m = 0;
    for (int i = MIN_BIN; i < HALF; i++) begin
      v = metric_f(mem_re[i], mem_im[i]);
      if (v > m) begin
        m = v;
        b = i;
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < N; i++) begin
      mem_re[i] = 0;
      mem_im[i] = 0;
    end
  endtask

  task automatic fill_random(input int mode);
    logic [15:0] r16;
    int          bin;
    clear_mem();
    for (int i = 0; i < N; i++) begin
      if (mode == 0) begin
        r16 = 16'($urandom);
        mem_re[i] = int'($signed(r16));
        r16 = 16'($urandom);
        mem_im[i] = int'($signed(r16));
      end else if (mode == 1) begin
        mem_re[i] = int'($urandom_range(0, 6)) - 3;
        mem_im[i] = int'($urandom_range(0, 6)) - 3;
      end
    end
    if (mode == 2) begin
      for (int s = 0; s < 3; s++) begin
        bin = int'($urandom_range(MIN_BIN, HALF - 1));
        mem_re[bin] = int'($urandom_range(0, 4000)) - 2000;
        mem_im[bin] = int'($urandom_range(0, 4000)) - 2000;
      end
    end
    // DC and the upper half must never win even when huge.
    mem_re[0] = 32767;
    mem_im[0] = 32767;
    mem_re[HALF + 3] = -32768;
    mem_im[HALF + 3] = -32768;
  endtask

  // done is raised in the current cycle (cycle 0); cycles 1..LAT+2 are observed.
  task automatic run_sweep(input string nm, input int exp_bin, input longint exp_mag,
                           input int rd1, input int rd2);
    int     seq_bad;
    int     first_bad;
    int     pv_cnt;
    int     pv_at;
    longint got_bin;
    longint got_mag;
    logic   exp_sel;
    logic   chk_adr;
    logic [M-1:0] exp_adr;
    seq_bad   = 0;
    first_bad = -1;
    pv_cnt    = 0;
    pv_at     = -1;
    got_bin   = -1;
    got_mag   = -1;
    done      = 1'b1;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(negedge clk);
      done = (k == rd1) || (k == rd2);
      if (k <= SWEEP_LEN) begin
        exp_sel = 1'b1;
        chk_adr = 1'b1;
        exp_adr = M'(MIN_BIN + k - 1);
      end else if (k <= SWEEP_LEN + DRAIN_CYC) begin
        exp_sel = 1'b1;
        chk_adr = 1'b1;
        exp_adr = M'(HALF - 1);
      end else begin
        exp_sel = 1'b0;
        chk_adr = 1'b0;
        exp_adr = '0;
      end
      if ((rd_sel !== exp_sel) || (busy !== exp_sel) || (chk_adr && (rd_adr !== exp_adr))) begin
        seq_bad++;
        if (first_bad < 0) first_bad = k;
      end
      if (peak_valid === 1'b1) begin
        pv_cnt++;
        pv_at   = k;
        got_bin = longint'(peak_bin);
        got_mag = longint'(peak_mag);
      end
    end
    done = 1'b0;
    if (first_bad >= 0) $display("note %s: first bad sweep cycle %0d", nm, first_bad);
    chk({nm, "_seq_bad_cycles"}, seq_bad, 0);
    chk({nm, "_pv_count"}, pv_cnt, 1);
    chk({nm, "_pv_cycle"}, pv_at, LAT);
    chk({nm, "_peak_bin"}, got_bin, exp_bin);
    chk({nm, "_peak_mag"}, got_mag, exp_mag);
    chk({nm, "_hold_bin"}, longint'(peak_bin), exp_bin);
    chk({nm, "_hold_mag"}, longint'(peak_mag), exp_mag);
  endtask

  initial begin
    vec_t   tbl[6];
    int     eb;
    longint em;
    int     pv_seen;
    int     sel_seen;

`ifdef FFT_PEAK_SQMAG_EN
    tbl[0] = '{40, 1000, -600, -1, 0, 0, -1, 0, 0, 40, 64'd1360000, -1, -1};
    tbl[1] = '{0, 30000, 0, 10, 500, 500, 20, 500, 500, 10, 64'd500000, -1, -1};
    tbl[2] = '{255, -32768, -32768, -1, 0, 0, -1, 0, 0, 255, 64'd2147483648, -1, -1};
    tbl[3] = '{-1, 0, 0, -1, 0, 0, -1, 0, 0, 1, 64'd0, 50, 257};
    tbl[4] = '{5, -100, 100, 200, 0, -201, -1, 0, 0, 200, 64'd40401, -1, -1};
    tbl[5] = '{1, 7, 7, 255, -14, 0, -1, 0, 0, 255, 64'd196, -1, -1};
`else
    tbl[0] = '{40, 1000, -600, -1, 0, 0, -1, 0, 0, 40, 64'd1600, -1, -1};
    tbl[1] = '{0, 30000, 0, 10, 500, 500, 20, 500, 500, 10, 64'd1000, -1, -1};
    tbl[2] = '{255, -32768, -32768, -1, 0, 0, -1, 0, 0, 255, 64'd65536, -1, -1};
    tbl[3] = '{-1, 0, 0, -1, 0, 0, -1, 0, 0, 1, 64'd0, 50, 257};
    tbl[4] = '{5, -100, 100, 200, 0, -201, -1, 0, 0, 200, 64'd201, -1, -1};
    tbl[5] = '{1, 7, 7, 255, -14, 0, -1, 0, 0, 1, 64'd14, -1, -1};
`endif

    clear_mem();
    reset = 1'b0;
    done  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rd_adr", longint'(rd_adr), 0);
    chk("rst_rd_sel", longint'(rd_sel), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_peak_valid", longint'(peak_valid), 0);
    chk("rst_peak_bin", longint'(peak_bin), 0);
    chk("rst_peak_mag", longint'(peak_mag), 0);
    reset = 1'b1;
    @(negedge clk);

    // Directed vectors run back to back, so vector 4 starts 259 cycles after vector 3.
    for (int v = 0; v < 6; v++) begin
      clear_mem();
      if (tbl[v].b0 >= 0) begin mem_re[tbl[v].b0] = tbl[v].r0; mem_im[tbl[v].b0] = tbl[v].i0; end
      if (tbl[v].b1 >= 0) begin mem_re[tbl[v].b1] = tbl[v].r1; mem_im[tbl[v].b1] = tbl[v].i1; end
      if (tbl[v].b2 >= 0) begin mem_re[tbl[v].b2] = tbl[v].r2; mem_im[tbl[v].b2] = tbl[v].i2; end
      run_sweep($sformatf("vec%0d", v), tbl[v].eb, tbl[v].em, tbl[v].rd1, tbl[v].rd2);
    end

    // Randomized sweeps against the array-scan model, with a stray done mid-sweep.
    for (int s = 0; s < 6; s++) begin
      fill_random(s % 3);
      model_peak(eb, em);
      run_sweep($sformatf("rnd%0d", s), eb, em, int'($urandom_range(2, SWEEP_LEN)), -1);
    end

    // Reset abort at cycle 100 of a sweep.
    fill_random(0);
    done = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      done = 1'b0;
    end
    reset = 1'b0;
    @(negedge clk);
    chk("abort_rd_adr", longint'(rd_adr), 0);
    chk("abort_rd_sel", longint'(rd_sel), 0);
    chk("abort_busy", longint'(busy), 0);
    chk("abort_peak_valid", longint'(peak_valid), 0);
    chk("abort_peak_bin", longint'(peak_bin), 0);
    chk("abort_peak_mag", longint'(peak_mag), 0);
    reset = 1'b1;
    pv_seen  = 0;
    sel_seen = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (peak_valid === 1'b1) pv_seen++;
      if (rd_sel !== 1'b0) sel_seen++;
    end
    chk("abort_no_peak_valid", pv_seen, 0);
    chk("abort_stays_idle", sel_seen, 0);
    fill_random(2);
    model_peak(eb, em);
    run_sweep("after_abort", eb, em, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
